// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing helper blocks.
//
// Contents:
//   ST_IDLE / ST_FIRE / ST_GAP   2-bit FSM state encodings for the pulse spacer
//   CDC_CNT_W_DEF                default pending-event counter width
//   CDC_MIN_GAP_DEF              default spacing between spaced output pulses
//   cdc_gap_w()                  width of a gap down-counter for a given spacing
package cdc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FIRE = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int CDC_CNT_W_DEF   = 4;
   localparam int CDC_MIN_GAP_DEF = 16;

   // The gap counter only has to hold MIN_GAP-2, so ceil(log2(MIN_GAP)) bits
   // suffice; never return zero so the counter stays a legal vector.
   function automatic int cdc_gap_w(input int min_gap);
      return (min_gap <= 2) ? 1 : $clog2(min_gap);
   endfunction

endpackage

// File: rtl/fast_pulse_spacer.sv
// Fast-domain pulse spacer: queues single-cycle event requests and replays
// them as single-cycle pulses at least MIN_GAP cycles apart, so a toggle
// synchronizer into a slower domain never misses one.
//
// Ports:
//   i_clk       fast clock, all logic on posedge
//   i_rst       synchronous active-high reset
//   i_pulse     event request, one event per high cycle
//   o_pulse     spaced single-cycle pulse (registered, state == FIRE)
//   o_busy      FSM not idle
//   o_pending   number of queued events not yet fired
//   o_overflow  one-cycle pulse the cycle after an event was dropped
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing in flight; leaves on a request or a queued event
// FIRE  | o_pulse high for exactly one cycle, one queued event consumed
// GAP   | spacing window, MIN_GAP-1 cycles timed by the gap down-counter
module fast_pulse_spacer
   import cdc_pkg::*;
#(
   parameter int CNT_W   = CDC_CNT_W_DEF,
   parameter int MIN_GAP = CDC_MIN_GAP_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pulse,
   output logic             o_pulse,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pending,
   output logic             o_overflow
);

   localparam int               GAP_W    = cdc_gap_w(MIN_GAP);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   generate
      if (MIN_GAP < 2 || MIN_GAP > 255 || CNT_W < 1) begin : g_param_check
         $error("fast_pulse_spacer: MIN_GAP must be 2..255 and CNT_W >= 1");
      end
   endgenerate

   logic [1:0]       state,   state_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [CNT_W-1:0] pending, pending_nxt;
   logic             overflow_q;
   logic             fire;
   logic             accept;
   logic             drop;

   assign fire = (state == ST_FIRE);

   // A full queue can still take a new event in FIRE because one slot is
   // freed in the same cycle.
   assign accept = i_pulse && !((pending == PEND_MAX) && !fire);
   assign drop   = i_pulse && !accept;

   always_comb begin
      pending_nxt = pending;
      case ({accept, fire})
         2'b10:   pending_nxt = pending + CNT_W'(1);
         2'b01:   pending_nxt = pending - CNT_W'(1);
         default: pending_nxt = pending;
      endcase
   end

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      case (state)
         ST_IDLE: begin
            if (i_pulse || (pending != '0)) begin
               state_nxt = ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
         end
         ST_GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = (pending != '0) ? ST_FIRE : ST_IDLE;
            end else begin
               gap_nxt = gap_cnt - GAP_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gap_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         pending    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         gap_cnt    <= gap_nxt;
         pending    <= pending_nxt;
         overflow_q <= drop;
      end
   end

   assign o_pulse    = fire;
   assign o_busy     = (state != ST_IDLE);
   assign o_pending  = pending;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fast_pulse_spacer.sv
module tb_fast_pulse_spacer;

   localparam int GAP_A = 4;
   localparam int MAX_A = 3;
   localparam int GAP_B = 16;
   localparam int MAX_B = 15;

   logic       i_clk = 1'b0;
   logic       clk_slow = 1'b0;
   logic       i_rst = 1'b1;
   logic       pulse_a = 1'b0;
   logic       pulse_b = 1'b0;

   logic       o_pulse_a, o_busy_a, o_ovf_a;
   logic [1:0] o_pend_a;
   logic       o_pulse_b, o_busy_b, o_ovf_b;
   logic [3:0] o_pend_b;

   int checks = 0;
   int errors = 0;

   fast_pulse_spacer #(.CNT_W(2), .MIN_GAP(GAP_A)) dut_a (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_pulse    (pulse_a),
      .o_pulse    (o_pulse_a),
      .o_busy     (o_busy_a),
      .o_pending  (o_pend_a),
      .o_overflow (o_ovf_a)
   );

   fast_pulse_spacer #(.CNT_W(4), .MIN_GAP(GAP_B)) dut_b (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_pulse    (pulse_b),
      .o_pulse    (o_pulse_b),
      .o_busy     (o_busy_b),
      .o_pending  (o_pend_b),
      .o_overflow (o_ovf_b)
   );

   always #5 i_clk = ~i_clk;
   initial begin
      #2;
      forever #20 clk_slow = ~clk_slow;
   end

   // Downstream toggle synchronizer into a 4x slower domain.
   logic tgl = 1'b0;
   logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
   int   slow_cnt = 0;
   always @(posedge i_clk) if (o_pulse_b === 1'b1) tgl <= ~tgl;
   always @(posedge clk_slow) begin
      s1 <= tgl;
      s2 <= s1;
      s3 <= s2;
      if (s2 != s3) slow_cnt <= slow_cnt + 1;
   end

   // Reference model: a queue length plus the time of the last fire. A pulse
   // is released as soon as the spacing window allows; the decision is made
   // one cycle ahead from the queue length, or from a fresh request when idle.
   typedef struct {
      int pend;
      int last_fire;
      bit fire;
      bit ovf;
      bit acc;
      int cyc;
   } mdl_t;

   function automatic mdl_t mdl_step(mdl_t m, bit rst, bit pulse, int gap, int maxp);
      mdl_t n;
      int   since;
      n.cyc = m.cyc + 1;
      if (rst) begin
         n.pend = 0; n.last_fire = -100000; n.fire = 0; n.ovf = 0; n.acc = 0;
         return n;
      end
      since  = m.cyc - m.last_fire;
      n.acc  = pulse && !(m.pend == maxp && !m.fire);
      n.ovf  = pulse && !n.acc;
      n.fire = (since >= gap - 1) && (m.pend > 0 || (pulse && since >= gap));
      n.pend = m.pend + int'(n.acc) - int'(m.fire);
      n.last_fire = n.fire ? n.cyc : m.last_fire;
      return n;
   endfunction

   mdl_t m_a, m_b;
   bit   mv = 0;
   int   acc_a = 0, acc_b = 0, np_a = 0, np_b = 0;

   task automatic chk_val(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(string nm, logic p, logic b, logic [3:0] pend, logic o,
                          mdl_t m, int gap);
      logic       eb;
      logic [3:0] ep;
      eb = (m.cyc - m.last_fire) < gap;
      ep = 4'(m.pend);
      checks++;
      if (p !== m.fire || b !== eb || pend !== ep || o !== m.ovf) begin
         errors++;
         $display("FAIL %s cyc=%0d: got pulse=%b busy=%b pend=%0d ovf=%b, want pulse=%b busy=%b pend=%0d ovf=%b",
                  nm, m.cyc, p, b, pend, o, m.fire, eb, ep, m.ovf);
      end
   endtask

   // Check current cycle against the model, then apply this cycle's inputs.
   task automatic step(bit rst, bit pa, bit pb);
      if (mv) begin
         chk_out("model_a", o_pulse_a, o_busy_a, {2'b00, o_pend_a}, o_ovf_a, m_a, GAP_A);
         chk_out("model_b", o_pulse_b, o_busy_b, o_pend_b, o_ovf_b, m_b, GAP_B);
      end
      i_rst   = rst;
      pulse_a = pa;
      pulse_b = pb;
      m_a = mdl_step(m_a, rst, pa, GAP_A, MAX_A);
      m_b = mdl_step(m_b, rst, pb, GAP_B, MAX_B);
      if (m_a.acc) acc_a++;
      if (m_b.acc) acc_b++;
      @(posedge i_clk);
      #1;
      if (o_pulse_a === 1'b1) np_a++;
      if (o_pulse_b === 1'b1) np_b++;
   endtask

   // {pulse_in, exp_pulse, exp_busy, exp_pend[1:0], exp_ovf}
   typedef struct packed {
      logic       pulse;
      logic       e_pulse;
      logic       e_busy;
      logic [1:0] e_pend;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[28];

   initial begin
      int base_slow, base_acc, events, pa0, aa0;

      for (int i = 0; i < 10; i++) tbl[i] = 6'b0_0_0_00_0;
      tbl[10] = 6'b1_0_0_00_0;
      tbl[11] = 6'b1_1_1_01_0;
      tbl[12] = 6'b1_0_1_01_0;
      tbl[13] = 6'b1_0_1_10_0;
      tbl[14] = 6'b1_0_1_11_0;
      tbl[15] = 6'b0_1_1_11_1;
      tbl[16] = 6'b0_0_1_10_0;
      tbl[17] = 6'b0_0_1_10_0;
      tbl[18] = 6'b0_0_1_10_0;
      tbl[19] = 6'b0_1_1_10_0;
      tbl[20] = 6'b0_0_1_01_0;
      tbl[21] = 6'b0_0_1_01_0;
      tbl[22] = 6'b0_0_1_01_0;
      tbl[23] = 6'b0_1_1_01_0;
      tbl[24] = 6'b0_0_1_00_0;
      tbl[25] = 6'b0_0_1_00_0;
      tbl[26] = 6'b0_0_1_00_0;
      tbl[27] = 6'b0_0_0_00_0;

      // Power-on reset, with a request present that must be ignored.
      i_rst = 1'b1;
      pulse_a = 1'b1;
      @(posedge i_clk);
      #1;
      m_a = mdl_step(m_a, 1'b1, 1'b0, GAP_A, MAX_A);
      m_b = mdl_step(m_b, 1'b1, 1'b0, GAP_B, MAX_B);
      m_a.cyc = 0;
      m_b.cyc = 0;
      mv = 1;
      chk_val("reset_state", {o_pulse_a, o_busy_a, o_pend_a, o_ovf_a}, 32'd0);
      step(1, 1, 0);

      // Burst of five into a depth-3 queue: one drop, four spaced pulses.
      for (int i = 0; i < 28; i++) begin
         chk_val($sformatf("tbl_%0d", i), {o_pulse_a, o_busy_a, o_pend_a, o_ovf_a},
                 {27'd0, tbl[i].e_pulse, tbl[i].e_busy, tbl[i].e_pend, tbl[i].e_ovf});
         step(0, tbl[i].pulse, 0);
      end

      // Single event: one pulse, busy for exactly MIN_GAP cycles.
      step(1, 0, 0);
      for (int c = 0; c < 17; c++) begin
         chk_val($sformatf("single_pulse_%0d", c), 32'(o_pulse_a), 32'(c == 11));
         chk_val($sformatf("single_busy_%0d", c), 32'(o_busy_a), 32'(c >= 11 && c <= 14));
         if (c == 11) chk_val("single_pend_11", 32'(o_pend_a), 32'd1);
         if (c == 12) chk_val("single_pend_12", 32'(o_pend_a), 32'd0);
         step(0, c == 10, 0);
      end

      // Reset mid-GAP with a request present discards the backlog; the
      // first request afterwards fires on the next cycle.
      step(1, 0, 0);
      pa0 = np_a;
      for (int c = 0; c < 24; c++) begin
         if (c == 17) begin
            chk_val("rst_mid_outputs", {o_pulse_a, o_busy_a, o_pend_a, o_ovf_a}, 32'd0);
            pa0 = np_a;
         end
         if (c == 21) begin
            chk_val("rst_no_extra_pulse", 32'(np_a - pa0), 32'd1);
            chk_val("rst_then_latency", 32'(o_pulse_a), 32'd1);
         end
         step(c == 16, (c >= 10 && c <= 12) || c == 16 || c == 20, 0);
      end

      // Continuous request: saturation, repeated drops, clean drain.
      step(1, 0, 0);
      pa0 = np_a;
      aa0 = acc_a;
      for (int c = 0; c < 40; c++) step(0, 1, 0);
      for (int c = 0; c < 30; c++) step(0, 0, 0);
      chk_val("hold_pulses_eq_accepted", 32'(np_a - pa0), 32'(acc_a - aa0));
      chk_val("hold_drained_idle", {o_busy_a, o_pend_a}, 32'd0);

      // Random requests with occasional reset.
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 0);
      end
      step(1, 0, 0);

      // Wide spacing into the slow domain: random bursts totalling 50 events.
      base_slow = slow_cnt;
      base_acc  = acc_b;
      events    = 0;
      while (events < 50) begin
         int len, idle;
         len  = $urandom_range(1, 4);
         idle = $urandom_range(0, 40);
         for (int k = 0; k < len && events < 50; k++) begin
            step(0, 0, 1);
            events++;
         end
         for (int k = 0; k < idle; k++) step(0, 0, 0);
      end
      for (int i = 0; i < 2000 && (m_b.pend != 0 || (m_b.cyc - m_b.last_fire) < GAP_B); i++) begin
         step(0, 0, 0);
      end
      for (int i = 0; i < 24; i++) step(0, 0, 0);
      chk_val("slow_count_eq_accepted", 32'(slow_cnt - base_slow), 32'(acc_b - base_acc));
      chk_val("wide_drained_idle", {o_busy_b, o_pend_b}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
